uart_rx_core: RTL and testbench

UART_RX_CORE -- requirements
Module: uart_rx_core

---
 rtl/uart_rx_core.sv | 190 +++++++++++++++++++
 tb/tb_uart_rx_core.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 serial receiver, LSB first, 4 oversample ticks per bit.
// A falling edge seen on a tick starts a frame. The start bit is confirmed
// two ticks later, at mid-bit. Each data bit and the stop bit are then
// sampled every fourth tick. A good frame goes into a single holding
// register with sticky overrun tracking. A bad stop bit sets a sticky
// framing error. The receiver then waits for the line to return high
// before it looks for a new start bit.
module uart_rx_core (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_rxclken,
   input  logic       i_rxd,
   input  logic       i_rdack,
   input  logic       i_clrerr,
   output logic [7:0] o_rxdata,
   output logic       o_rxrdy,
   output logic       o_ferr,
   output logic       o_overrun,
   output logic       o_busy
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_WAITHI
   } state_t;

   // Synchronizer chain; rxs is the only view of the line used by decisions.
   logic       sync_q1;
   logic       rxs;

   // Receiver state and datapath registers, plus their next values.
   state_t     state,    state_nx;
   logic [1:0] tick_cnt, tick_nx;
   logic [2:0] bit_cnt,  bit_nx;
   logic [7:0] shift,    shift_nx;

   // Single-cycle events raised by the FSM on the stop-bit sampling tick.
   logic       load_byte;
   logic       frame_err;

   // Bring the asynchronous line into the clock domain; idle level is high.
   // NOTE: sequential blocks use non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         sync_q1 <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         sync_q1 <= i_rxd;
         rxs     <= sync_q1;
      end
   end

   // FSM and datapath registers; next values already respect i_rxclken.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state    <= ST_IDLE;
         tick_cnt <= 2'd0;
         bit_cnt  <= 3'd0;
         shift    <= 8'h00;
      end else begin
         state    <= state_nx;
         tick_cnt <= tick_nx;
         bit_cnt  <= bit_nx;
         shift    <= shift_nx;
      end
   end

   // Next-state and tick/bit/shift update; all movement is gated by a tick.
   // NOTE: every always_comb output is defaulted first so no path can infer a latch.
   always_comb begin
      state_nx  = state;
      tick_nx   = tick_cnt;
      bit_nx    = bit_cnt;
      shift_nx  = shift;
      load_byte = 1'b0;
      frame_err = 1'b0;

      if (i_rxclken) begin
         case (state)
            ST_IDLE: begin
               if (!rxs) begin
                  state_nx = ST_START;
                  tick_nx  = 2'd0;
               end
            end

            ST_START: begin
               // Second tick after detection is the middle of the start bit.
               if (tick_cnt == 2'd1) begin
                  if (!rxs) begin
                     state_nx = ST_DATA;
                     tick_nx  = 2'd0;
                     bit_nx   = 3'd0;
                  end else begin
                     // Short low glitch: drop it without touching any flag.
                     state_nx = ST_IDLE;
                     tick_nx  = 2'd0;
                  end
               end else begin
                  tick_nx = tick_cnt + 2'd1;
               end
            end

            ST_DATA: begin
               if (tick_cnt == 2'd3) begin
                  // LSB arrives first, so shift right and insert at bit 7.
                  shift_nx = {rxs, shift[7:1]};
                  tick_nx  = 2'd0;
                  if (bit_cnt == 3'd7) begin
                     state_nx = ST_STOP;
                     bit_nx   = 3'd0;
                  end else begin
                     bit_nx = bit_cnt + 3'd1;
                  end
               end else begin
                  tick_nx = tick_cnt + 2'd1;
               end
            end

            ST_STOP: begin
               if (tick_cnt == 2'd3) begin
                  tick_nx = 2'd0;
                  if (rxs) begin
                     load_byte = 1'b1;
                     state_nx  = ST_IDLE;
                  end else begin
                     frame_err = 1'b1;
                     state_nx  = ST_WAITHI;
                  end
               end else begin
                  tick_nx = tick_cnt + 2'd1;
               end
            end

            ST_WAITHI: begin
               // A break or stuck-low line must not look like a new start bit.
               if (rxs) begin
                  state_nx = ST_IDLE;
               end
            end

            default: begin
               state_nx = ST_IDLE;
               tick_nx  = 2'd0;
               bit_nx   = 3'd0;
            end
         endcase
      end
   end

   // Holding register and ready flag; a load beats a simultaneous read-ack.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_rxdata <= 8'h00;
         o_rxrdy  <= 1'b0;
      end else if (load_byte) begin
         o_rxdata <= shift;
         o_rxrdy  <= 1'b1;
      end else if (i_rdack) begin
         o_rxrdy  <= 1'b0;
      end
   end

   // Sticky error flags; setting wins over a clear in the same cycle.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_ferr    <= 1'b0;
         o_overrun <= 1'b0;
      end else begin
         if (frame_err) begin
            o_ferr <= 1'b1;
         end else if (i_clrerr) begin
            o_ferr <= 1'b0;
         end

         // An ack in the load cycle frees the holding register in time.
         if (load_byte && o_rxrdy && !i_rdack) begin
            o_overrun <= 1'b1;
         end else if (i_clrerr) begin
            o_overrun <= 1'b0;
         end
      end
   end

   assign o_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed and random frames against a frame-level model.
// The line is driven one bit per four ticks, with a tick every 8 clocks.
// Counted from the tick that carries the start edge, the stop sample falls
// on tick 39. That is the fourth tick of the stop bit. The count comes from
// the 2-flop synchronizer, detection on the next tick, the mid-start check
// two ticks later, and a sample every fourth tick after that.
module tb_uart_rx_core;

   logic       clk = 1'b0;
   logic       reset;
   logic       rxclken;
   logic       rxd;
   logic       rdack;
   logic       clrerr;
   logic [7:0] rxdata;
   logic       rxrdy;
   logic       ferr;
   logic       overrun;
   logic       busy;

   int n_tests = 0;
   int n_fail  = 0;

   // Frame-level reference model of the host-visible registers.
   logic [7:0] m_data;
   logic       m_rdy;
   logic       m_ferr;
   logic       m_ovr;

   logic [7:0] rb;
   logic       rstop;
   logic       rrd;
   logic       rclr;

   uart_rx_core dut (
      .i_clk     (clk),
      .i_reset   (reset),
      .i_rxclken (rxclken),
      .i_rxd     (rxd),
      .i_rdack   (rdack),
      .i_clrerr  (clrerr),
      .o_rxdata  (rxdata),
      .o_rxrdy   (rxrdy),
      .o_ferr    (ferr),
      .o_overrun (overrun),
      .o_busy    (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic exp_busy);
      check({tag, ".rxdata"},  rxdata,  m_data);
      check({tag, ".rxrdy"},   {7'd0, rxrdy},   {7'd0, m_rdy});
      check({tag, ".ferr"},    {7'd0, ferr},    {7'd0, m_ferr});
      check({tag, ".overrun"}, {7'd0, overrun}, {7'd0, m_ovr});
      check({tag, ".busy"},    {7'd0, busy},    {7'd0, exp_busy});
   endtask

   // Model of the end of one frame, optionally with host pulses in that cycle.
   task automatic model_frame(input logic [7:0] b, input logic stop_ok,
                              input logic rd, input logic clr);
      if (stop_ok) begin
         if (m_rdy && !rd) m_ovr = 1'b1;
         else if (clr)     m_ovr = 1'b0;
         if (clr) m_ferr = 1'b0;
         m_data = b;
         m_rdy  = 1'b1;
      end else begin
         m_ferr = 1'b1;
         if (rd)  m_rdy = 1'b0;
         if (clr) m_ovr = 1'b0;
      end
   endtask

   task automatic model_reset();
      m_data = 8'h00;
      m_rdy  = 1'b0;
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
   endtask

   // One tick period of 8 clocks, entered and left on a falling edge.
   task automatic tick_p(input logic rd, input logic clr);
      rxclken = 1'b1;
      rdack   = rd;
      clrerr  = clr;
      @(negedge clk);
      rxclken = 1'b0;
      rdack   = 1'b0;
      clrerr  = 1'b0;
      repeat (7) @(negedge clk);
   endtask

   task automatic idle_ticks(input int n);
      rxd = 1'b1;
      for (int i = 0; i < n; i++) tick_p(1'b0, 1'b0);
   endtask

   // Full frame; rd/clr pulses land on the stop-sample tick (tick 39).
   task automatic send_frame(input logic [7:0] b, input logic stop_ok,
                             input logic rd, input logic clr);
      logic [9:0] bits;
      bits = {stop_ok, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rxd = bits[i];
         for (int t = 0; t < 4; t++) begin
            if (i == 9 && t == 3) tick_p(rd, clr);
            else                  tick_p(1'b0, 1'b0);
         end
      end
   endtask

   task automatic pulse_rdack();
      rdack = 1'b1;
      @(negedge clk);
      rdack = 1'b0;
      m_rdy = 1'b0;
   endtask

   task automatic pulse_clrerr();
      clrerr = 1'b1;
      @(negedge clk);
      clrerr = 1'b0;
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
   endtask

   initial begin
      reset   = 1'b1;
      rxclken = 1'b0;
      rxd     = 1'b1;
      rdack   = 1'b0;
      clrerr  = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check_all("reset", 1'b0);
      reset = 1'b0;
      @(negedge clk);
      idle_ticks(2);
      check_all("idle", 1'b0);

      // Basic good frame.
      send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
      model_frame(8'hA5, 1'b1, 1'b0, 1'b0);
      check_all("a5", 1'b0);
      pulse_rdack();
      check("a5.ack", {7'd0, rxrdy}, {7'd0, m_rdy});

      // One-tick low glitch: START is entered and then abandoned.
      rxd = 1'b0;
      tick_p(1'b0, 1'b0);
      rxd = 1'b1;
      tick_p(1'b0, 1'b0);
      check("glitch.start", {7'd0, busy}, 8'd1);
      tick_p(1'b0, 1'b0);
      tick_p(1'b0, 1'b0);
      check_all("glitch.idle", 1'b0);

      // Bad stop with the line low for three bit times, then a good frame.
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
      model_frame(8'h3C, 1'b0, 1'b0, 1'b0);
      check_all("ferr.low", 1'b1);
      rxd = 1'b0;
      for (int i = 0; i < 8; i++) tick_p(1'b0, 1'b0);
      check_all("ferr.hold", 1'b1);
      idle_ticks(3);
      check_all("ferr.high", 1'b0);
      send_frame(8'h55, 1'b1, 1'b0, 1'b0);
      model_frame(8'h55, 1'b1, 1'b0, 1'b0);
      check_all("f55", 1'b0);
      pulse_clrerr();
      pulse_rdack();
      check_all("f55.clr", 1'b0);

      // Two frames without an ack produce an overrun.
      send_frame(8'h11, 1'b1, 1'b0, 1'b0);
      model_frame(8'h11, 1'b1, 1'b0, 1'b0);
      send_frame(8'h22, 1'b1, 1'b0, 1'b0);
      model_frame(8'h22, 1'b1, 1'b0, 1'b0);
      check_all("ovr", 1'b0);
      pulse_clrerr();
      check_all("ovr.clr", 1'b0);

      // Ack in the exact load cycle: no overrun, new data, still ready.
      send_frame(8'h7E, 1'b1, 1'b1, 1'b0);
      model_frame(8'h7E, 1'b1, 1'b1, 1'b0);
      check_all("ack_load", 1'b0);

      // Clear in the load cycle of an overrun: the set wins.
      send_frame(8'h5A, 1'b1, 1'b0, 1'b1);
      model_frame(8'h5A, 1'b1, 1'b0, 1'b1);
      check_all("set_wins", 1'b0);

      // Reset during data bit 4 of 0xFF, then a clean frame.
      rxd = 1'b0;
      for (int t = 0; t < 4; t++) tick_p(1'b0, 1'b0);
      rxd = 1'b1;
      for (int t = 0; t < 18; t++) tick_p(1'b0, 1'b0);
      check("rst.busy_before", {7'd0, busy}, 8'd1);
      #2 reset = 1'b1;
      #1 model_reset();
      check_all("rst.async", 1'b0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      idle_ticks(24);
      check_all("rst.after", 1'b0);
      send_frame(8'h81, 1'b1, 1'b0, 1'b0);
      model_frame(8'h81, 1'b1, 1'b0, 1'b0);
      check_all("f81", 1'b0);

      // Random frames with random stop quality and host pulses.
      for (int k = 0; k < 12; k++) begin
         rb    = 8'($urandom);
         rstop = ($urandom_range(0, 3) != 0);
         rrd   = 1'($urandom_range(0, 1));
         rclr  = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 1) == 1) pulse_rdack();
         send_frame(rb, rstop, rrd, rclr);
         model_frame(rb, rstop, rrd, rclr);
         check_all("rnd.end", !rstop);
         if (!rstop) begin
            rxd = 1'b0;
            for (int i = 0; i < 4; i++) tick_p(1'b0, 1'b0);
            check("rnd.waithi", {7'd0, busy}, 8'd1);
         end
         idle_ticks(2);
         check_all("rnd.idle", 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
